// File: rtl/xcorr_pkg.sv
// Shared helpers for the lag cross-correlator: baseline enumeration,
// saturating accumulate and the readout state encoding.
package xcorr_pkg;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOAD,
    RD_STREAM
  } rd_state_e;

  function automatic int xcorr_nb(input int n);
    return n * (n + 1) / 2;
  endfunction

  // Baseline b -> {i[31:16], j[15:0]}, pairs enumerated i-major with i<=j.
  function automatic logic [31:0] xcorr_pair(input int b, input int n);
    int k;
    logic [31:0] r;
    logic done;
    k    = b;
    r    = '0;
    done = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!done) begin
        if (k < n - i) begin
          r    = {16'(i), 16'(i + k)};
          done = 1'b1;
        end else begin
          k = k - (n - i);
        end
      end
    end
    return r;
  endfunction

  // Symmetric clip to +/-(2^(res-1)-1); clip reports when the limit was applied.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int res,
                                                 output logic clip);
    logic signed [64:0] s;
    logic signed [64:0] mx;
    s    = {a[63], a} + {b[63], b};
    mx   = (65'sd1 <<< (res - 1)) - 65'sd1;
    clip = 1'b0;
    if (s > mx) begin
      clip = 1'b1;
      return mx[63:0];
    end else if (s < -mx) begin
      clip = 1'b1;
      return (-mx);
    end
    return s[63:0];
  endfunction

endpackage

// File: rtl/xcorr_lag_line.sv
// Per-input sample history; tap l presents the sample from l accepted beats ago.
module xcorr_lag_line #(
  parameter int NUM_LAGS   = 8,
  parameter int WORD_WIDTH = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 shift_en,
  input  logic [WORD_WIDTH-1:0]                din,
  output logic [NUM_LAGS-1:0][WORD_WIDTH-1:0]  taps
);

  // Tap 0 is the live sample, so only NUM_LAGS-1 words need storage.
  logic [NUM_LAGS-2:0][WORD_WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (shift_en) begin
      sr[0] <= din;
      for (int k = 1; k < NUM_LAGS - 1; k++) sr[k] <= sr[k-1];
    end
  end

  assign taps = {sr, din};

endmodule

// File: rtl/xcorr_integrator.sv
// Multi-baseline lag cross-correlator with saturating accumulators,
// a snapshot bank dumped every integ_len beats and a valid/ready readout.
module xcorr_integrator
  import xcorr_pkg::*;
#(
  parameter int  NUM_INPUTS = 4,
  parameter int  NUM_LAGS   = 8,
  parameter int  WORD_WIDTH = 4,
  parameter int  RESOLUTION = 24,
  localparam int NB         = xcorr_nb(NUM_INPUTS),
  localparam int BW         = (NB > 1) ? $clog2(NB) : 1,
  localparam int LW         = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic                             in_valid,
  input  logic [WORD_WIDTH*NUM_INPUTS-1:0] in_data,
  input  logic [31:0]                      integ_len,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RESOLUTION-1:0]            out_data,
  output logic [BW-1:0]                    out_baseline,
  output logic [LW-1:0]                    out_lag,
  output logic                             out_last,
  output logic                             overrun,
  output logic                             saturated
);

  localparam int PW = 2 * WORD_WIDTH;

  logic accept;
  logic hit;
  logic [31:0] cnt_q, len_q;
  logic [NUM_INPUTS-1:0][NUM_LAGS-1:0][WORD_WIDTH-1:0] taps;
  logic vld_q, last_q;
  logic dump, rd_free, take, at_last;
  logic [NB-1:0][NUM_LAGS-1:0][RESOLUTION-1:0] snap_all;
  logic [NB*NUM_LAGS-1:0] clip_all;
  rd_state_e state_q, state_d;
  logic [BW-1:0] rb_q;
  logic [LW-1:0] rl_q;

  assign accept = in_valid & enable;
  assign hit    = accept && (len_q != 32'd0) && (cnt_q + 32'd1 == len_q);

  // The new length is picked up on the closing beat, so it governs exactly the next integration.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      len_q <= integ_len;
    end else if (accept) begin
      if (hit) begin
        cnt_q <= '0;
        len_q <= integ_len;
      end else begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_line
    xcorr_lag_line #(
      .NUM_LAGS  (NUM_LAGS),
      .WORD_WIDTH(WORD_WIDTH)
    ) u_line (
      .clk     (clk),
      .reset   (reset),
      .shift_en(accept),
      .din     (in_data[k*WORD_WIDTH +: WORD_WIDTH]),
      .taps    (taps[k])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      vld_q  <= accept;
      last_q <= hit;
    end
  end

  assign dump    = vld_q & last_q;
  assign at_last = (rb_q == BW'(NB - 1)) && (rl_q == LW'(NUM_LAGS - 1));
  // The bank may be overwritten only when nothing is streaming, or on the very last handshake.
  assign rd_free = (state_q == RD_IDLE) ||
                   ((state_q == RD_STREAM) && out_ready && at_last);
  assign take    = dump & rd_free;

  for (genvar b = 0; b < NB; b++) begin : g_bl
    localparam logic [31:0] PR = xcorr_pair(b, NUM_INPUTS);
    localparam int BI = int'(PR[31:16]);
    localparam int BJ = int'(PR[15:0]);
    for (genvar l = 0; l < NUM_LAGS; l++) begin : g_lag
      logic signed [PW-1:0] prod_r;
      logic [RESOLUTION-1:0] acc_r, snap_r, acc_d;
      logic clip_d;

      always_ff @(posedge clk) begin
        if (reset) prod_r <= '0;
        else if (accept)
          prod_r <= PW'($signed(taps[BI][0])) * PW'($signed(taps[BJ][l]));
      end

      always_comb begin
        clip_d = 1'b0;
        acc_d  = RESOLUTION'(sat_add(64'($signed(acc_r)), 64'(prod_r),
                                     RESOLUTION, clip_d));
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          acc_r  <= '0;
          snap_r <= '0;
        end else begin
          if (vld_q) acc_r <= last_q ? '0 : acc_d;
          if (take)  snap_r <= acc_d;
        end
      end

      assign snap_all[b][l]         = snap_r;
      assign clip_all[b*NUM_LAGS+l] = clip_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      saturated <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (vld_q && (|clip_all)) saturated <= 1'b1;
      if (dump && !rd_free)     overrun   <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RD_IDLE;
    else       state_q <= state_d;
  end

  // LOAD spaces out_valid one cycle behind the snapshot write; a dump on the
  // final handshake skips it and restarts the stream directly.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RD_IDLE:   if (take) state_d = RD_LOAD;
      RD_LOAD:   state_d = RD_STREAM;
      RD_STREAM: if (out_ready && at_last) state_d = take ? RD_STREAM : RD_IDLE;
      default:   state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || take) begin
      rb_q <= '0;
      rl_q <= '0;
    end else if ((state_q == RD_STREAM) && out_ready) begin
      if (rl_q == LW'(NUM_LAGS - 1)) begin
        rl_q <= '0;
        rb_q <= at_last ? '0 : rb_q + BW'(1);
      end else begin
        rl_q <= rl_q + LW'(1);
      end
    end
  end

  always_comb begin
    out_valid    = (state_q == RD_STREAM);
    out_last     = out_valid & at_last;
    out_baseline = rb_q;
    out_lag      = rl_q;
    out_data     = out_valid ? snap_all[rb_q][rl_q] : '0;
  end

endmodule
